// File: rtl/cache_line_fill_pkg.sv
// Shared cache definitions: refill FSM state encodings and a constant-friendly clog2.
package cache_line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic int myclog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Cache line refill engine: fetches one line from memory into the data RAM, forwards the
// missed word, then commits the tag. Define CACHE_CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module cache_line_fill
    import cache_line_fill_pkg::*;
#(
    parameter int nr_entries = 32,
    parameter int line_words = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           miss,
    input  logic [31:0]                                    miss_addr,
    output logic                                           busy,
    output logic                                           m_access,
    output logic [31:0]                                    m_addr,
    input  logic                                           m_ack,
    input  logic [31:0]                                    m_data,
    output logic                                           ram_wr_en,
    output logic [myclog2(nr_entries)-1:0]                 ram_write_addr,
    output logic [31:0]                                    ram_write_data,
    output logic [3:0]                                     ram_bytesel,
    output logic                                           crit_valid,
    output logic [31:0]                                    crit_data,
    output logic                                           tag_wr_en,
    output logic [myclog2(nr_entries)-myclog2(line_words)-1:0] tag_index,
    output logic                                           fill_done
);

    localparam int addr_bits = myclog2(nr_entries);
    localparam int offs_bits = myclog2(line_words);
    localparam int idx_bits  = addr_bits - offs_bits;
    localparam logic [offs_bits:0] last_cnt = (offs_bits + 1)'(line_words - 1);

    state_t                 state_q, state_d;
    logic [31:2]            addr_q, addr_d;
    logic [offs_bits-1:0]   offs_q, offs_d;
    logic [offs_bits:0]     count_q, count_d;

    logic                   in_fill;
    logic                   ack;
    logic [offs_bits-1:0]   crit_offs;
    logic [idx_bits-1:0]    line_idx;
    logic                   unused_byte_offs;

    assign in_fill   = (state_q == FILL);
    assign ack       = in_fill & m_ack;
    assign crit_offs = addr_q[offs_bits+1:2];
    assign line_idx  = addr_q[addr_bits+1:offs_bits+2];
    assign unused_byte_offs = ^miss_addr[1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        offs_d  = offs_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    addr_d  = miss_addr[31:2];
                    count_d = '0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                    offs_d  = miss_addr[offs_bits+1:2];
`else
                    offs_d  = '0;
`endif
                    state_d = FILL;
                end
            end
            FILL: begin
                // Offset wraps naturally at line_words since it is exactly offs_bits wide.
                if (m_ack) begin
                    offs_d  = offs_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == last_cnt) state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            offs_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            offs_q  <= offs_d;
            count_q <= count_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign m_access       = in_fill;
    assign m_addr         = in_fill ? {addr_q[31:offs_bits+2], offs_q, 2'b00} : 32'd0;

    // RAM write happens in the ack cycle itself; data is not registered.
    assign ram_wr_en      = ack;
    assign ram_bytesel    = ack ? 4'hf : 4'h0;
    assign ram_write_addr = {line_idx, offs_q};
    assign ram_write_data = m_data;

    assign crit_valid     = ack && (offs_q == crit_offs);
    assign crit_data      = m_data;

    assign tag_wr_en      = (state_q == COMMIT);
    assign fill_done      = (state_q == COMMIT);
    assign tag_index      = line_idx;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill (nr_entries=32, line_words=8); expectations follow CACHE_CRITICAL_WORD_FIRST_EN.
module tb_cache_line_fill;
    import cache_line_fill_pkg::*;

    localparam int NE = 32;
    localparam int LW = 8;
    localparam int AB = myclog2(NE);
    localparam int OB = myclog2(LW);

    logic          clk = 1'b0;
    logic          rst, miss, m_ack;
    logic [31:0]   miss_addr, m_data;
    logic          busy, m_access, ram_wr_en, crit_valid, tag_wr_en, fill_done;
    logic [31:0]   m_addr, ram_write_data, crit_data;
    logic [AB-1:0] ram_write_addr;
    logic [3:0]    ram_bytesel;
    logic [AB-OB-1:0] tag_index;

    cache_line_fill #(.nr_entries(NE), .line_words(LW)) dut (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .busy(busy),
        .m_access(m_access), .m_addr(m_addr), .m_ack(m_ack), .m_data(m_data),
        .ram_wr_en(ram_wr_en), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_bytesel(ram_bytesel),
        .crit_valid(crit_valid), .crit_data(crit_data), .tag_wr_en(tag_wr_en),
        .tag_index(tag_index), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   maddr;
        logic [AB-1:0] waddr;
        logic          crit;
    } vec_t;

    vec_t tbl[LW];
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, done_cnt = 0, tag_cnt = 0;

    always @(negedge clk) begin
        if (ram_wr_en) wr_cnt++;
        if (fill_done) done_cnt++;
        if (tag_wr_en) tag_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hD00D_0000 | a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [31:0] a);
        miss = 1'b1;
        miss_addr = a;
        cyc();
        miss = 1'b0;
    endtask

    // Waits 'delay' idle cycles, then acks word i; table checks only when use_tbl is set.
    task automatic ack_word(input int i, input int delay, input bit use_tbl);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            if (use_tbl) begin
                chk("wait_maddr", m_addr, tbl[i].maddr);
                chk("wait_access", m_access, 1);
                chk("wait_no_wr", ram_wr_en, 0);
            end
            cyc();
        end
        m_ack  = 1'b1;
        m_data = use_tbl ? mem_word(tbl[i].maddr) : (32'h1234_0000 + i);
        @(negedge clk);
        if (use_tbl) begin
            chk("ack_maddr", m_addr, tbl[i].maddr);
            chk("ack_wr_en", ram_wr_en, 1);
            chk("ack_waddr", ram_write_addr, tbl[i].waddr);
            chk("ack_wdata", ram_write_data, mem_word(tbl[i].maddr));
            chk("ack_bytesel", ram_bytesel, 4'hf);
            chk("ack_crit", crit_valid, tbl[i].crit);
            if (tbl[i].crit) chk("crit_data", crit_data, mem_word(32'h54));
        end
        cyc();
        m_ack = 1'b0;
    endtask

    task automatic check_commit(input logic [31:0] idx);
        @(negedge clk);
        chk("commit_access", m_access, 0);
        chk("commit_tag_wr", tag_wr_en, 1);
        chk("commit_done", fill_done, 1);
        chk("commit_index", tag_index, idx);
        chk("commit_no_wr", ram_wr_en, 0);
        cyc();
        @(negedge clk);
        chk("post_commit_busy", busy, 0);
        chk("post_commit_tag", tag_wr_en, 0);
    endtask

    int w0, d0, t0;

    initial begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        tbl[0] = '{32'h54, 5'd21, 1'b1};
        tbl[1] = '{32'h58, 5'd22, 1'b0};
        tbl[2] = '{32'h5C, 5'd23, 1'b0};
        tbl[3] = '{32'h40, 5'd16, 1'b0};
        tbl[4] = '{32'h44, 5'd17, 1'b0};
        tbl[5] = '{32'h48, 5'd18, 1'b0};
        tbl[6] = '{32'h4C, 5'd19, 1'b0};
        tbl[7] = '{32'h50, 5'd20, 1'b0};
`else
        tbl[0] = '{32'h40, 5'd16, 1'b0};
        tbl[1] = '{32'h44, 5'd17, 1'b0};
        tbl[2] = '{32'h48, 5'd18, 1'b0};
        tbl[3] = '{32'h4C, 5'd19, 1'b0};
        tbl[4] = '{32'h50, 5'd20, 1'b0};
        tbl[5] = '{32'h54, 5'd21, 1'b1};
        tbl[6] = '{32'h58, 5'd22, 1'b0};
        tbl[7] = '{32'h5C, 5'd23, 1'b0};
`endif
        rst = 1'b1; miss = 1'b0; miss_addr = '0; m_ack = 1'b0; m_data = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_access", m_access, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_crit", crit_valid, 0);
        chk("rst_tag", tag_wr_en, 0);
        chk("rst_done", fill_done, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Immediate acks
        start_fill(32'h54);
        @(negedge clk);
        chk("fill_busy", busy, 1);
        cyc();
        for (int i = 0; i < LW; i++) ack_word(i, 0, 1'b1);
        check_commit(2);
        cyc();

        // Back-pressure plus ignored miss mid-fill
        w0 = wr_cnt; d0 = done_cnt;
        start_fill(32'h54);
        for (int i = 0; i < LW; i++) begin
            if (i == 3) begin miss = 1'b1; miss_addr = 32'h2C; end
            ack_word(i, 3, 1'b1);
            miss = 1'b0;
        end
        check_commit(2);
        cyc();
        chk("bp_writes", wr_cnt - w0, 8);
        chk("bp_done", done_cnt - d0, 1);

        // Stray ack in IDLE
        w0 = wr_cnt;
        m_ack = 1'b1; m_data = 32'hBAD0_0000;
        @(negedge clk);
        chk("stray_no_wr", ram_wr_en, 0);
        cyc();
        m_ack = 1'b0;
        @(negedge clk);
        chk("stray_idle", busy, 0);
        cyc();
        chk("stray_writes", wr_cnt - w0, 0);

        // Reset after the 4th ack
        t0 = tag_cnt;
        start_fill(32'h54);
        for (int i = 0; i < 4; i++) ack_word(i, 0, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_access", m_access, 0);
        chk("abort_maddr", m_addr, 0);
        chk("abort_wr_en", ram_wr_en, 0);
        chk("abort_crit", crit_valid, 0);
        chk("abort_tag", tag_wr_en, 0);
        chk("abort_done", fill_done, 0);
        cyc(); cyc(); cyc();
        chk("abort_no_tag", tag_cnt - t0, 0);

        // Back-to-back: miss held through COMMIT, new address latched on return to IDLE
        miss = 1'b1; miss_addr = 32'h54;
        cyc();
        miss_addr = 32'h2C;
        for (int i = 0; i < LW; i++) ack_word(i, 0, 1'b1);
        check_commit(2);
        cyc();
        miss = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy, 1);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        chk("b2b_first_maddr", m_addr, 32'h2C);
`else
        chk("b2b_first_maddr", m_addr, 32'h20);
`endif
        cyc();
        for (int i = 0; i < LW; i++) ack_word(i, 0, 1'b0);
        check_commit(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 SHALL have parameter nr_entries, default 32: number of 32-bit words in the data RAM being filled.
REQ-002 SHALL have parameter line_words, default 8: words per cache line, a power of two, at least 2, and dividing nr_entries.
REQ-003 SHALL derive localparams addr_bits = myclog2(nr_entries) and offs_bits = myclog2(line_words).
REQ-004 SHALL have ports, one per line, as follows:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- miss  in  1  refill request, sampled only in IDLE.
- miss_addr  in  32  byte address of the missing access.
- busy  out  1  refill in progress (any state other than IDLE).
- m_access  out  1  memory read request.
- m_addr  out  32  word-aligned memory read address.
- m_ack  in  1  memory read data valid this cycle.
- m_data  in  32  memory read data.
- ram_wr_en  out  1  data-RAM write enable.
- ram_write_addr  out  addr_bits  data-RAM word address.
- ram_write_data  out  32  data-RAM write data.
- ram_bytesel  out  4  data-RAM byte enables.
- crit_valid  out  1  one-cycle pulse: the missed word is on crit_data.
- crit_data  out  32  missed word, forwarded to the CPU.
- tag_wr_en  out  1  one-cycle pulse: write the tag and set the valid bit for the line.
- tag_index  out  addr_bits-offs_bits  line index to tag.
- fill_done  out  1  one-cycle pulse: refill complete.

Function
REQ-005 SHALL implement the states IDLE, FILL and COMMIT.
REQ-006 In IDLE with miss=1, SHALL latch miss_addr, set word count to 0, and enter FILL on the next edge.
REQ-007 In FILL, SHALL drive m_access=1 and m_addr = {line base, offset, 2'b00}, where line base = latched address bits [31:offs_bits+2].
REQ-008 In FILL, m_access SHALL stay high until every word has been acknowledged.
- m_addr changes only on the cycle after an m_ack.
REQ-009 On each cycle with m_ack=1 in FILL:
- ram_wr_en=1, ram_bytesel=4'hf, ram_write_data=m_data, combinationally in that same cycle.
- ram_write_addr = {latched addr[addr_bits+1:offs_bits+2], offset}.
- offset advances mod line_words; count increments.
REQ-010 On the m_ack whose offset equals miss_addr[offs_bits+1:2], SHALL pulse crit_valid with crit_data=m_data.
REQ-011 After the line_words-th m_ack, SHALL enter COMMIT.
- In COMMIT: m_access=0, tag_wr_en=1, fill_done=1, tag_index = latched addr[addr_bits+1:offs_bits+2].
- Then return to IDLE.
REQ-012 Fill latency SHALL be line_words acks plus two cycles: one request-setup cycle and one COMMIT cycle.
REQ-013 miss asserted while busy SHALL be ignored; it SHALL NOT be queued.
REQ-014 m_ack outside FILL SHALL be ignored: no RAM write and no state change.
REQ-015 ram_wr_en, crit_valid, tag_wr_en and fill_done SHALL be 0 in every cycle not listed in REQ-009 to REQ-011.

Reset
REQ-016 rst=1 SHALL force IDLE on the next edge, including mid-FILL.
REQ-017 Reset values SHALL be: busy, m_access, ram_wr_en, crit_valid, tag_wr_en and fill_done all 0; m_addr, offset and count all 0.
REQ-018 A fill aborted by reset SHALL NOT produce tag_wr_en; partially written RAM words remain invalid because the tag is never set.

Configuration
REQ-019 With CACHE_CRITICAL_WORD_FIRST_EN defined, the fill SHALL start at offset = miss_addr[offs_bits+1:2] and wrap to 0 after line_words-1, so crit_valid fires on the first m_ack.
REQ-020 Without CACHE_CRITICAL_WORD_FIRST_EN, the fill SHALL start at offset 0 and proceed ascending; crit_valid fires when the missed offset arrives.

Structure
REQ-021 The state encodings (IDLE=2'd0, FILL=2'd1, COMMIT=2'd2) and myclog2 SHALL live in the shared cache package, used by the cache controller and the bench.
REQ-022 SHALL be one flat module with no sub-module; its write port connects directly to cache_data_ram's write port.

Verification (nr_entries=32, line_words=8)
REQ-023 The bench SHALL cover:
- Critical-word wrap: macro on, miss_addr=0x00000054, immediate acks → m_addr sequence 0x54,0x58,0x5C,0x40,0x44,0x48,0x4C,0x50; ram_write_addr 21,22,23,16,17,18,19,20; crit_valid on the first ack; tag_index=2.
- Ascending fill: macro off, same miss → m_addr 0x40..0x5C ascending; crit_valid on the 6th ack with crit_data equal to the word at 0x54.
- Back-pressure: m_ack delayed 3 cycles per word → m_addr stable until each ack; exactly 8 RAM writes; fill_done exactly once.
- Ignored requests: miss pulsed mid-fill, and stray m_ack in IDLE → no second fill, no RAM write.
- Mid-fill reset: rst=1 after the 4th ack → next cycle IDLE with all outputs 0; tag_wr_en never asserted.
- Back-to-back fills: miss held high through COMMIT → a new fill starts the cycle after returning to IDLE, with the new address latched.
